clint_mh: RTL and testbench
===========================

Name: clint_mh

Overview:
- Multi-hart core-local interruptor; next generation of the single-hart machine timer.
- Holds one shared 64-bit mtime, plus one msip and one 64-bit mtimecmp per hart.
- Generates per-hart timer and software interrupts to each hart's CSR unit.
- Sits on the core data bus as a slave with a registered one-cycle read/write response.
- Adds over the previous block: a programmable tick prescaler, a debug freeze, a writable mtime, and a standard unsigned compare.

Parameters:
- NUM_HARTS, 2, number of harts served; 1..16.
- DATA_WIDTH, 32, bus data width; fixed at 32 for this generation.
- TICK_DIV, 1, clk_i cycles per mtime increment; 1..65535; 1 means increment every cycle.

Ports:
- clk_i  in  1  single clock for all logic.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  1  bus request.
- we_i  in  1  write when high, read when low; qualified by req_i.
- addr_i  in  DATA_WIDTH  byte address; only [15:0] is decoded; [1:0] is ignored.
- data_i  in  DATA_WIDTH  write data.
- data_o  out  DATA_WIDTH  registered read data.
- ack_o  out  1  registered response strobe, one cycle after req_i.
- halt_i  in  1  debug halt; freezes mtime and the prescaler.
- timer_irq_o  out  NUM_HARTS  per-hart timer interrupt, registered.
- software_irq_o  out  NUM_HARTS  per-hart software interrupt, equal to msip[h] bit 0.

Behaviour:
- Reset (rst_i high at posedge): values applied at that edge.
  - mtime = 0; prescaler count = 0.
  - All msip = 0; all mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, so no interrupt out of reset.
  - data_o = 0, ack_o = 0, timer_irq_o = 0, software_irq_o = 0.
  - Reset mid-transaction drops that transaction; no ack is issued.
- Address map (addr_i[15:0]):
  - msip[h] at 0x0000 + 4h.
  - mtimecmp[h] low word at 0x4000 + 8h; high word at 0x4004 + 8h.
  - mtime low at 0xBFF8; mtime high at 0xBFFC.
  - Any h >= NUM_HARTS, or any other address, is unmapped.
- Bus handshake:
  - Every cycle with req_i high is accepted; there is no stall.
  - ack_o pulses high in the following cycle; back-to-back requests give back-to-back acks.
  - Reads: data_o is loaded at the accept edge with the value held before that edge. Unmapped reads return 0. data_o = 0 whenever ack_o is low.
  - Writes: committed at the accept edge. Unmapped writes are ignored but still acked.
  - msip stores data_i[0] only; reads return it zero-extended.
- Prescaler:
  - Counter runs 0..TICK_DIV-1. tick is asserted when count == TICK_DIV-1, then the counter wraps to 0.
  - With TICK_DIV=1, tick is asserted every cycle.
  - While halt_i is high, both the counter and mtime hold.
- mtime update, in priority order:
  - A bus write to mtime low or high updates that word only. The other word holds. The increment is suppressed that cycle. The prescaler is cleared to 0.
  - Otherwise, on tick, mtime = mtime + 1 as a full 64-bit add, carrying into the high word; 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
- Bus writes never block the increment except writes to mtime itself. An msip/mtimecmp write and a tick in the same cycle both take effect.
- Interrupts, registered every cycle:
  - timer_irq_o[h] = (mtime >= mtimecmp[h]), unsigned 64-bit, using current register values. It is one cycle behind any mtime/mtimecmp change.
  - mtimecmp[h] = 0 is legal and fires immediately (no zero-disable).
  - software_irq_o[h] = msip[h], visible the cycle after the write edge.
- Software updates mtimecmp one 32-bit half at a time. The transient compare on the half-written value is accepted; the recommended sequence is high=all-ones, low, high.

Decomposition:
- Shared package/defines file holds:
  - Base offsets MSIP_BASE, MTIMECMP_BASE, MTIME_ADDR.
  - Per-hart strides (4 for msip, 8 for mtimecmp).
  - MTIMECMP_RESET = all-ones.
  - Existing RESET_ENABLE / CHIP_ENABLE / ZERO macros.
- One sub-module, clint_prescaler (counter, halt, clear, tick_o). Everything else stays in clint_mh, with per-hart storage as generate-indexed arrays.

Test Plan:
- Reset then idle, TICK_DIV=1, 10 cycles -> mtime low reads 10 (±read latency accounted); all irqs 0; ack_o 1 cycle after each req_i.
- TICK_DIV=4, halt_i high for cycles 20-29 -> mtime advances 1 per 4 clocks and does not advance during halt; resumes with the prescaler count unchanged.
- Write mtime low=FFFF_FFFE, high=0, one tick per cycle -> after 2 ticks high=1, low=0; mtime write in the same cycle as a tick keeps the written value.
- Hart 1: mtimecmp low=100, high=0 with mtime=90 -> timer_irq_o[1] rises exactly the cycle after mtime reaches 100; timer_irq_o[0] stays 0; writing mtimecmp high=1 clears it next cycle.
- Write msip[0]=0xFFFF_FFFF, then read it -> software_irq_o[0]=1 next cycle, read returns 1; write 0 -> irq drops.
- Read/write 0x0008 with NUM_HARTS=2 and 0x1234 -> read data 0, ack still pulses, no state change; reset asserted during a pending ack -> ack_o 0.

Source files
------------

// File: rtl/clint_mh_pkg.sv
// clint_mh shared definitions: address map, strides and reset values.
`default_nettype none

package clint_mh_pkg;

  localparam logic [15:0] MSIP_BASE       = 16'h0000;
  localparam logic [15:0] MTIMECMP_BASE   = 16'h4000;
  localparam logic [15:0] MTIME_ADDR      = 16'hBFF8;
  localparam int          MSIP_STRIDE     = 4;
  localparam int          MTIMECMP_STRIDE = 8;
  localparam logic [63:0] MTIMECMP_RESET  = 64'hFFFF_FFFF_FFFF_FFFF;

  localparam logic        RESET_ENABLE    = 1'b1;
  localparam logic        CHIP_ENABLE     = 1'b1;
  localparam logic [31:0] ZERO            = 32'd0;

endpackage

`default_nettype wire

// File: rtl/clint_prescaler.sv
// clint_prescaler: divides clk_i into mtime ticks; freezes on halt, clears on mtime write.
`default_nettype none

module clint_prescaler
  import clint_mh_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic halt_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

  logic [15:0] count;

  assign tick_o = !halt_i && (count == LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i == RESET_ENABLE || clear_i) begin
      count <= 16'd0;
    end else if (!halt_i) begin
      count <= (count == LAST) ? 16'd0 : count + 16'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/clint_mh.sv
// clint_mh: multi-hart core-local interruptor with shared mtime, per-hart msip/mtimecmp.
`default_nettype none

module clint_mh
  import clint_mh_pkg::*;
#(
  parameter int NUM_HARTS  = 2,
  parameter int DATA_WIDTH = 32,
  parameter int TICK_DIV   = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  ack_o,
  input  logic                  halt_i,
  output logic [NUM_HARTS-1:0]  timer_irq_o,
  output logic [NUM_HARTS-1:0]  software_irq_o
);

  logic [15:0]           addr;
  logic                  wr;
  logic                  mtime_lo_sel;
  logic                  mtime_hi_sel;
  logic                  mtime_wr;
  logic                  tick;
  logic [63:0]           mtime;
  logic [NUM_HARTS-1:0]  msip;
  logic [NUM_HARTS-1:0]  msip_sel;
  logic [NUM_HARTS-1:0]  cmp_lo_sel;
  logic [NUM_HARTS-1:0]  cmp_hi_sel;
  logic [63:0]           mtimecmp [NUM_HARTS];
  logic [DATA_WIDTH-1:0] rdata;
  logic                  unused_addr_bits;

  // Only [15:2] participate in decoding.
  assign unused_addr_bits = &{addr_i[DATA_WIDTH-1:16], addr_i[1:0]};
  assign addr         = {addr_i[15:2], 2'b00};
  assign wr           = (req_i == CHIP_ENABLE) && we_i;
  assign mtime_lo_sel = (addr == MTIME_ADDR);
  assign mtime_hi_sel = (addr == MTIME_ADDR + 16'd4);
  assign mtime_wr     = wr && (mtime_lo_sel || mtime_hi_sel);

  clint_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .halt_i  (halt_i),
    .clear_i (mtime_wr),
    .tick_o  (tick)
  );

  // A write to either mtime word overrides the tick for that cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i == RESET_ENABLE) begin
      mtime <= 64'd0;
    end else if (wr && mtime_lo_sel) begin
      mtime[31:0] <= data_i;
    end else if (wr && mtime_hi_sel) begin
      mtime[63:32] <= data_i;
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  generate
    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
      localparam logic [15:0] MSIP_A = MSIP_BASE + 16'(MSIP_STRIDE * h);
      localparam logic [15:0] CMP_A  = MTIMECMP_BASE + 16'(MTIMECMP_STRIDE * h);

      logic [63:0] cmp_q;
      logic        msip_q;
      logic        irq_q;

      assign msip_sel[h]   = (addr == MSIP_A);
      assign cmp_lo_sel[h] = (addr == CMP_A);
      assign cmp_hi_sel[h] = (addr == CMP_A + 16'd4);
      assign mtimecmp[h]   = cmp_q;
      assign msip[h]       = msip_q;
      assign timer_irq_o[h] = irq_q;

      always_ff @(posedge clk_i) begin
        if (rst_i == RESET_ENABLE) begin
          cmp_q  <= MTIMECMP_RESET;
          msip_q <= 1'b0;
          irq_q  <= 1'b0;
        end else begin
          if (wr && cmp_lo_sel[h]) cmp_q[31:0]  <= data_i;
          if (wr && cmp_hi_sel[h]) cmp_q[63:32] <= data_i;
          if (wr && msip_sel[h])   msip_q       <= data_i[0];
          irq_q <= (mtime >= cmp_q);
        end
      end
    end
  endgenerate

  assign software_irq_o = msip;

  always_comb begin
    rdata = ZERO;
    if (mtime_lo_sel) rdata = mtime[31:0];
    if (mtime_hi_sel) rdata = mtime[63:32];
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (msip_sel[h])   rdata = {31'd0, msip[h]};
      if (cmp_lo_sel[h]) rdata = mtimecmp[h][31:0];
      if (cmp_hi_sel[h]) rdata = mtimecmp[h][63:32];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i == RESET_ENABLE) begin
      ack_o  <= 1'b0;
      data_o <= ZERO;
    end else begin
      ack_o  <= (req_i == CHIP_ENABLE);
      data_o <= ((req_i == CHIP_ENABLE) && !we_i) ? rdata : ZERO;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_clint_mh.sv
// tb_clint_mh: scoreboard bench for clint_mh (TICK_DIV=1 and TICK_DIV=4 instances).
`default_nettype none

module tb_clint_mh;

  logic        clk;
  logic        rst_a, req_a, we_a, halt_a, ack_a;
  logic [31:0] addr_a, wdata_a, data_a;
  logic [1:0]  tirq_a, sirq_a;
  logic        rst_b, req_b, we_b, halt_b, ack_b;
  logic [31:0] addr_b, wdata_b, data_b;
  logic [1:0]  tirq_b, sirq_b;

  int          cmp_cnt = 0;
  int          err_cnt = 0;
  logic [32:0] exp_q[$];
  logic [32:0] obs_q[$];
  logic        got_ack;

  clint_mh #(.NUM_HARTS(2), .DATA_WIDTH(32), .TICK_DIV(1)) dut_a (
    .clk_i(clk), .rst_i(rst_a), .req_i(req_a), .we_i(we_a), .addr_i(addr_a),
    .data_i(wdata_a), .data_o(data_a), .ack_o(ack_a), .halt_i(halt_a),
    .timer_irq_o(tirq_a), .software_irq_o(sirq_a)
  );

  clint_mh #(.NUM_HARTS(2), .DATA_WIDTH(32), .TICK_DIV(4)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .req_i(req_b), .we_i(we_b), .addr_i(addr_b),
    .data_i(wdata_b), .data_o(data_b), .ack_o(ack_b), .halt_i(halt_b),
    .timer_irq_o(tirq_b), .software_irq_o(sirq_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Each bus op starts at a negedge, consumes one posedge, and returns at the next negedge.
  task automatic bus_a(input logic w, input logic [31:0] ad, input logic [31:0] wd);
    req_a = 1'b1; we_a = w; addr_a = ad; wdata_a = wd;
    @(posedge clk); #1;
    got_ack = ack_a;
    if (!w) obs_q.push_back({ack_a, data_a});
    @(negedge clk);
    req_a = 1'b0; we_a = 1'b0;
  endtask

  task automatic rd_b(input logic [31:0] ad);
    req_b = 1'b1; we_b = 1'b0; addr_b = ad;
    @(posedge clk); #1;
    obs_q.push_back({ack_b, data_b});
    @(negedge clk);
    req_b = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [32:0] e, o;
    rst_a = 1'b1;
    idle(2);
    cmp_cnt++;
    if ({ack_a, data_a, tirq_a, sirq_a} !== 37'd0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got ack=%b data=%h tirq=%b sirq=%b required all 0",
               ack_a, data_a, tirq_a, sirq_a);
    end
    rst_a = 1'b0;
    idle(10);
    exp_q.push_back({1'b1, 32'd10});
    bus_a(1'b0, 32'h0000_BFF8, 32'd0);
    exp_q.push_back({1'b1, 32'd0});
    bus_a(1'b0, 32'h0000_BFFC, 32'd0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 33'd0;
      cmp_cnt++;
      if (o !== e) begin
        err_cnt++;
        $display("FAIL reset_read: got {ack,data}=%h required %h", o, e);
      end
    end
  endtask

  task automatic test_prescaler();
    logic [32:0] e, o;
    rst_b = 1'b1;
    idle(2);
    rst_b = 1'b0;
    idle(20);
    exp_q.push_back({1'b1, 32'd5});
    rd_b(32'h0000_BFF8);
    halt_b = 1'b1;
    idle(10);
    exp_q.push_back({1'b1, 32'd5});
    rd_b(32'h0000_BFF8);
    halt_b = 1'b0;
    idle(2);
    exp_q.push_back({1'b1, 32'd5});
    rd_b(32'h0000_BFF8);
    exp_q.push_back({1'b1, 32'd6});
    rd_b(32'h0000_BFF8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 33'd0;
      cmp_cnt++;
      if (o !== e) begin
        err_cnt++;
        $display("FAIL prescaler_read: got {ack,data}=%h required %h", o, e);
      end
    end
  endtask

  task automatic test_mtime_carry();
    logic [32:0] e, o;
    bus_a(1'b1, 32'h0000_BFF8, 32'hFFFF_FFFE);
    bus_a(1'b1, 32'h0000_BFFC, 32'h0000_0000);
    idle(2);
    exp_q.push_back({1'b1, 32'h0000_0000});
    bus_a(1'b0, 32'h0000_BFF8, 32'd0);
    exp_q.push_back({1'b1, 32'h0000_0001});
    bus_a(1'b0, 32'h0000_BFFC, 32'd0);
    bus_a(1'b1, 32'h0000_BFF8, 32'h0000_0055);
    exp_q.push_back({1'b1, 32'h0000_0055});
    bus_a(1'b0, 32'h0000_BFF8, 32'd0);
    exp_q.push_back({1'b1, 32'h0000_0001});
    bus_a(1'b0, 32'h0000_BFFC, 32'd0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 33'd0;
      cmp_cnt++;
      if (o !== e) begin
        err_cnt++;
        $display("FAIL mtime_carry_read: got {ack,data}=%h required %h", o, e);
      end
    end
  endtask

  task automatic test_timer_irq();
    bus_a(1'b1, 32'h0000_BFF8, 32'd0);
    bus_a(1'b1, 32'h0000_BFFC, 32'd0);
    bus_a(1'b1, 32'h0000_BFF8, 32'd90);
    bus_a(1'b1, 32'h0000_4008, 32'd100);
    bus_a(1'b1, 32'h0000_400C, 32'd0);
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      cmp_cnt++;
      if (tirq_a !== {(k == 9), 1'b0}) begin
        err_cnt++;
        $display("FAIL timer_irq_rise k=%0d: got %b required %b", k, tirq_a, {(k == 9), 1'b0});
      end
    end
    @(negedge clk);
    bus_a(1'b1, 32'h0000_400C, 32'd1);
    cmp_cnt++;
    if (tirq_a !== 2'b10) begin
      err_cnt++;
      $display("FAIL timer_irq_hold: got %b required 10", tirq_a);
    end
    @(posedge clk); #1;
    cmp_cnt++;
    if (tirq_a !== 2'b00) begin
      err_cnt++;
      $display("FAIL timer_irq_clear: got %b required 00", tirq_a);
    end
    @(negedge clk);
  endtask

  task automatic test_msip();
    logic [32:0] e, o;
    bus_a(1'b1, 32'h0000_0000, 32'hFFFF_FFFF);
    cmp_cnt++;
    if (sirq_a !== 2'b01) begin
      err_cnt++;
      $display("FAIL msip_set: got %b required 01", sirq_a);
    end
    exp_q.push_back({1'b1, 32'd1});
    bus_a(1'b0, 32'h0000_0000, 32'd0);
    bus_a(1'b1, 32'h0000_0004, 32'd1);
    cmp_cnt++;
    if (sirq_a !== 2'b11) begin
      err_cnt++;
      $display("FAIL msip_hart1: got %b required 11", sirq_a);
    end
    bus_a(1'b1, 32'h0000_0000, 32'd0);
    bus_a(1'b1, 32'h0000_0004, 32'd0);
    cmp_cnt++;
    if (sirq_a !== 2'b00) begin
      err_cnt++;
      $display("FAIL msip_clear: got %b required 00", sirq_a);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 33'd0;
      cmp_cnt++;
      if (o !== e) begin
        err_cnt++;
        $display("FAIL msip_read: got {ack,data}=%h required %h", o, e);
      end
    end
  endtask

  task automatic test_unmapped();
    logic [32:0] e, o;
    bus_a(1'b1, 32'h0000_0008, 32'd1);
    cmp_cnt++;
    if (got_ack !== 1'b1 || sirq_a !== 2'b00) begin
      err_cnt++;
      $display("FAIL unmapped_write: got ack=%b sirq=%b required ack=1 sirq=00", got_ack, sirq_a);
    end
    bus_a(1'b1, 32'h0000_1234, 32'hFFFF_FFFF);
    exp_q.push_back({1'b1, 32'd0});
    bus_a(1'b0, 32'h0000_0008, 32'd0);
    exp_q.push_back({1'b1, 32'd0});
    bus_a(1'b0, 32'h0000_1234, 32'd0);
    exp_q.push_back({1'b1, 32'd0});
    bus_a(1'b0, 32'h0000_4010, 32'd0);
    exp_q.push_back({1'b1, 32'd0});
    bus_a(1'b0, 32'h0000_0000, 32'd0);
    exp_q.push_back({1'b1, 32'd100});
    bus_a(1'b0, 32'h0000_4008, 32'd0);
    exp_q.push_back({1'b1, 32'd1});
    bus_a(1'b0, 32'h0000_400C, 32'd0);
    exp_q.push_back({1'b1, 32'hFFFF_FFFF});
    bus_a(1'b0, 32'h0000_4004, 32'd0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 33'd0;
      cmp_cnt++;
      if (o !== e) begin
        err_cnt++;
        $display("FAIL unmapped_read: got {ack,data}=%h required %h", o, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [32:0] e, o;
    exp_q.push_back({1'b1, 32'd0});
    exp_q.push_back({1'b1, 32'd100});
    req_a = 1'b1; we_a = 1'b0; addr_a = 32'h0000_0000;
    @(posedge clk); #1;
    obs_q.push_back({ack_a, data_a});
    @(negedge clk);
    addr_a = 32'h0000_4008;
    @(posedge clk); #1;
    obs_q.push_back({ack_a, data_a});
    @(negedge clk);
    req_a = 1'b0;
    @(posedge clk); #1;
    cmp_cnt++;
    if (ack_a !== 1'b0 || data_a !== 32'd0) begin
      err_cnt++;
      $display("FAIL b2b_idle: got ack=%b data=%h required ack=0 data=0", ack_a, data_a);
    end
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 33'd0;
      cmp_cnt++;
      if (o !== e) begin
        err_cnt++;
        $display("FAIL b2b_read: got {ack,data}=%h required %h", o, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [32:0] e, o;
    req_a = 1'b1; we_a = 1'b0; addr_a = 32'h0000_4008; rst_a = 1'b1;
    @(posedge clk); #1;
    cmp_cnt++;
    if (ack_a !== 1'b0 || data_a !== 32'd0) begin
      err_cnt++;
      $display("FAIL reset_mid_ack: got ack=%b data=%h required ack=0 data=0", ack_a, data_a);
    end
    @(negedge clk);
    req_a = 1'b0;
    idle(1);
    rst_a = 1'b0;
    exp_q.push_back({1'b1, 32'hFFFF_FFFF});
    bus_a(1'b0, 32'h0000_400C, 32'd0);
    exp_q.push_back({1'b1, 32'd0});
    bus_a(1'b0, 32'h0000_BFFC, 32'd0);
    cmp_cnt++;
    if (tirq_a !== 2'b00) begin
      err_cnt++;
      $display("FAIL reset_mid_irq: got %b required 00", tirq_a);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 33'd0;
      cmp_cnt++;
      if (o !== e) begin
        err_cnt++;
        $display("FAIL reset_mid_read: got {ack,data}=%h required %h", o, e);
      end
    end
  endtask

  initial begin
    rst_a = 1'b1; req_a = 1'b0; we_a = 1'b0; halt_a = 1'b0; addr_a = '0; wdata_a = '0;
    rst_b = 1'b1; req_b = 1'b0; we_b = 1'b0; halt_b = 1'b0; addr_b = '0; wdata_b = '0;
    got_ack = 1'b0;
    @(negedge clk);
    test_reset();
    test_prescaler();
    test_mtime_carry();
    test_timer_irq();
    test_msip();
    test_unmapped();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

`default_nettype wire
